// File: rtl/slow_memory_arb_if.sv
// Request/response bus between NCH cache channels and the shared slow memory.
// Channel i uses slice i of every vector.
interface slow_memory_arb_if #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
);
  // Handshake: a channel raises read or write (level) with a stable addr/wdata and
  // holds them until it sees its one-cycle mem_ready pulse, then drops the request.
  // mem_rdata slice i is meaningful only while mem_ready[i] is high.
  logic [NCH-1:0]        mem_read;
  logic [NCH-1:0]        mem_write;
  logic [NCH*ADDR_W-1:0] mem_addr;
  logic [NCH*LINE_W-1:0] mem_wdata;
  logic [NCH*LINE_W-1:0] mem_rdata;
  logic [NCH-1:0]        mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/slow_memory_arb.sv
// Shared line-wide slow memory serving NCH channels through a round-robin arbiter
// with a programmable, cycle-exact access latency and a sticky protocol-error flag.
module slow_memory_arb #(
  parameter int NCH        = 2,
  parameter int ADDR_W     = 28,
  parameter int LINE_W     = 128,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4,
  localparam int GW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  slow_memory_arb_if.slave     m,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic [31:0]          access_cnt,
  output logic                 proto_err,
  output logic [1:0]           dbg_state
);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_WAIT = 2'd1,
    DONE       = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [GW-1:0]         rr_ptr;
  logic [GW-1:0]         g;
  logic                  op_wr;
  logic [DEPTH_LOG2-1:0] idx;
  logic [LINE_W-1:0]     wdata_q;
  logic [CNT_W-1:0]      cnt;
  logic                  req_any;
  logic [GW-1:0]         req_sel;
  logic [GW-1:0]         cand;
  logic                  unused_addr;

  logic [LINE_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Walk offsets from the far end so the channel closest to rr_ptr wins.
  always_comb begin
    req_any = 1'b0;
    req_sel = '0;
    cand    = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = GW'((int'(rr_ptr) + k) % NCH);
      if (m.mem_read[cand] | m.mem_write[cand]) begin
        req_any = 1'b1;
        req_sel = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (req_any) state_next = (LATENCY > 1) ? GRANT_WAIT : DONE;
      GRANT_WAIT: if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      g          <= '0;
      op_wr      <= 1'b0;
      idx        <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      access_cnt <= '0;
      proto_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (|(m.mem_read & m.mem_write)) proto_err <= 1'b1;
      case (state)
        IDLE: if (req_any) begin
          g       <= req_sel;
          op_wr   <= m.mem_write[req_sel];
          idx     <= m.mem_addr[int'(req_sel)*ADDR_W +: DEPTH_LOG2];
          wdata_q <= m.mem_wdata[int'(req_sel)*LINE_W +: LINE_W];
          cnt     <= CNT_W'(LATENCY - 1);
        end
        GRANT_WAIT: cnt <= cnt - CNT_W'(1);
        DONE: begin
          access_cnt <= access_cnt + 32'd1;
          rr_ptr     <= GW'((int'(g) + 1) % NCH);
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset so benches can preload it; an asserted
  // reset suppresses the commit of an abandoned write.
  always_ff @(posedge clk) begin
    if (!rst && state == DONE && op_wr) mem[idx] <= wdata_q;
  end

  always_comb begin
    m.mem_ready = '0;
    m.mem_rdata = '0;
    if (state == DONE) begin
      m.mem_ready[g] = 1'b1;
      if (!op_wr) m.mem_rdata[int'(g)*LINE_W +: LINE_W] = mem[idx];
    end
  end

  assign busy        = (state != IDLE);
  assign grant_id    = busy ? g : '0;
  assign dbg_state   = state;
  assign unused_addr = ^m.mem_addr;
endmodule

// File: doc/slow_memory_arb.md
Name: slow_memory_arb

Overview:
- Parametrised successor to the single-port slow memory model used in the CHIP simulation top.
- Serves NCH independent cache channels (I/D, L2, and so on) from one shared line-wide storage array.
- Uses a round-robin arbiter, a programmable access latency and a sticky protocol-error flag.
- Allows benches to model I-cache and D-cache contention for one off-chip memory, with a cycle-exact, parametrised turnaround.

Parameters:
NCH, 2, number of requesting channels (≥1)
ADDR_W, 28, line-address width per channel (byte address bits [31:4])
LINE_W, 128, data line width in bits
DEPTH_LOG2, 10, log2 of storage depth in lines; the index is addr[DEPTH_LOG2-1:0]
LATENCY, 4, cycles from request acceptance to the ready pulse (≥1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_read  in  NCH  per-channel read request, level, held until ready
mem_write  in  NCH  per-channel write request, level, held until ready
mem_addr  in  NCH*ADDR_W  per-channel line address, channel i at slice [i*ADDR_W +: ADDR_W]
mem_wdata  in  NCH*LINE_W  per-channel write line
mem_rdata  out  NCH*LINE_W  per-channel read line, valid only while that channel's ready is high
mem_ready  out  NCH  per-channel one-cycle completion pulse
busy  out  1  high while a transaction is granted (GRANT_WAIT or DONE)
grant_id  out  max(1,$clog2(NCH))  index of the channel currently served, 0 when idle
access_cnt  out  32  completed transactions, wraps at 2^32
proto_err  out  1  sticky; set when any channel asserts read and write in the same cycle

Behaviour:
- Reset values: mem_ready=0, mem_rdata=0, busy=0, grant_id=0, access_cnt=0, proto_err=0, RR pointer=0, FSM=IDLE. The storage array `mem` is not reset; it is loadable by $readmemh/$readmemb via hierarchical name.
- FSM has three states: IDLE, GRANT_WAIT and DONE.
- IDLE:
  - A channel requests when read|write is high.
  - Choose the first requesting channel at or after the RR pointer, modulo NCH.
  - On the clock edge: latch channel id, op (write wins if both are high), index and wdata. Load the counter with LATENCY-1.
  - Next state is GRANT_WAIT when LATENCY>1, otherwise DONE.
  - If nothing is requesting, stay in IDLE.
- GRANT_WAIT: decrement the counter each cycle. When the counter reaches 1, next state is DONE. Request inputs are ignored in this state; the latched values are used.
- DONE, lasting one cycle:
  - mem_ready[g]=1 for the granted channel only.
  - Read: mem_rdata slice g = mem[index]. All other slices are 0.
  - Write: mem[index] <= latched wdata at the end of DONE; mem_rdata slice g = 0.
  - access_cnt increments.
  - RR pointer <= (g+1) mod NCH.
  - Next state is IDLE unconditionally.
- Latency: request visible in cycle t (FSM in IDLE) gives ready high exactly in cycle t+LATENCY.
- Turnaround: at least one IDLE cycle between transactions. A requester deasserts after seeing ready, so it is never double-served.
- Requests arriving during GRANT_WAIT or DONE wait in place; no request is dropped while it is held.
- Fairness: with all channels requesting continuously, grants rotate 0,1,…,NCH-1,0,…
- Read-after-write to the same index: a read granted after the write's DONE returns the new data.
- proto_err is set in the cycle after any channel shows read&write=1, in any state. It clears only on rst.
- Reset mid-transaction: abandons the transaction immediately. No write commit, no ready pulse, and access_cnt is not incremented.
- Out-of-range address bits above DEPTH_LOG2 are ignored, so addresses alias.

Test Plan:
- Single read, NCH=2, LATENCY=4: preload mem[5]=128'hA5…; ch0 read addr 5 at t=0 → mem_ready[0] high only at t=4 with rdata slice0=A5…; access_cnt=1; busy high t=1..4.
- Write then read: ch1 write addr 3 data 128'h1234; after its ready, ch1 read addr 3 → rdata slice1=128'h1234; access_cnt=2.
- Contention: ch0 and ch1 both read from t=0, each holding its request until it sees ready → ch0 ready at t=4, ch1 ready at t=9, with grant_id 0 then 1. Continuous requests from both channels alternate 0,1,0,1.
- LATENCY=1: request at t=0 → ready at t=1; back-to-back requests from the same channel give ready every 2 cycles.
- Protocol error: ch0 asserts read and write to addr 7 with data X → proto_err=1 the next cycle and stays set; the operation performed is a write (mem[7]=X).
- Reset during GRANT_WAIT of a write to addr 9 (old value Y): assert rst → all outputs are at reset values, mem[9] still equals Y, access_cnt=0; a new request after reset is served normally.
